// File: rtl/accel_pkg.sv
// Shared types and defaults for the accelerator lease arbiter.
package accel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    FLUSH = 2'd2
  } lease_state_e;

  localparam int LEASE_TIMEOUT_DEF = 1024;
  localparam int FLUSH_CYCLES_DEF  = 4;

  // Index/counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set bit of req above last, wrapping.
module rr_pick
  import accel_pkg::*;
#(
  parameter  int N    = 2,
  localparam int ID_W = clog2_min1(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic [ID_W-1:0] sel,
  output logic            any
);

  logic [ID_W-1:0] cand;

  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise the tools infer a latch to hold the old value.
    sel  = '0;
    any  = 1'b0;
    cand = '0;
    // Walk from the farthest offset down so the nearest requester wins.
    for (int off = N; off >= 1; off--) begin
      cand = ID_W'((int'(last) + off) % N);
      if (req[cand]) begin
        any = 1'b1;
        sel = cand;
      end
    end
  end

endmodule

// File: rtl/accel_lease_arbiter.sv
// Round-robin lease arbiter for the shared encryption accelerator, with an
// idle watchdog and a mandatory accelerator flush after every lease.
module accel_lease_arbiter
  import accel_pkg::*;
#(
  parameter  int N_CLIENTS     = 2,
  parameter  int LEASE_TIMEOUT = LEASE_TIMEOUT_DEF,
  parameter  int FLUSH_CYCLES  = FLUSH_CYCLES_DEF,
  localparam int ID_W          = clog2_min1(N_CLIENTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CLIENTS-1:0] req_i,
  input  logic [N_CLIENTS-1:0] rel_i,
  input  logic [N_CLIENTS-1:0] act_i,
  output logic [N_CLIENTS-1:0] gnt_o,
  output logic [ID_W-1:0]      owner_o,
  output logic                 busy_o,
  output logic                 accel_rst_o,
  output logic                 timeout_o,
  output logic [ID_W-1:0]      timeout_id_o
);

  localparam int WD_W = clog2_min1(LEASE_TIMEOUT);
  localparam int FC_W = clog2_min1(FLUSH_CYCLES);

  localparam logic [WD_W-1:0]      WD_MAX = WD_W'(LEASE_TIMEOUT - 1);
  localparam logic [FC_W-1:0]      FC_MAX = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [N_CLIENTS-1:0] ONE    = N_CLIENTS'(1);

  lease_state_e           state_q, state_d;
  logic [N_CLIENTS-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]        owner_q, owner_d;
  logic                   busy_q, busy_d;
  logic                   accel_rst_q, accel_rst_d;
  logic                   timeout_q, timeout_d;
  logic [ID_W-1:0]        timeout_id_q, timeout_id_d;
  logic [ID_W-1:0]        last_q, last_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic [FC_W-1:0]        flush_cnt_q, flush_cnt_d;

  logic [ID_W-1:0] pick_sel;
  logic            pick_any;

  logic own_req, own_rel, own_act, wd_expire, lease_end, reclaim;

  rr_pick #(.N(N_CLIENTS)) u_rr_pick (
    .req  (req_i),
    .last (last_q),
    .sel  (pick_sel),
    .any  (pick_any)
  );

  // Only the owner's strobes matter; everyone else's are don't-cares.
  assign own_req   = req_i[owner_q];
  assign own_rel   = rel_i[owner_q];
  assign own_act   = act_i[owner_q];
  assign wd_expire = (wd_q == WD_MAX) && !own_act;
  assign lease_end = own_rel || !own_req || wd_expire;
  assign reclaim   = wd_expire && !own_rel && own_req;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    busy_d       = busy_q;
    accel_rst_d  = accel_rst_q;
    timeout_d    = 1'b0;
    timeout_id_d = timeout_id_q;
    last_d       = last_q;
    wd_d         = wd_q;
    flush_cnt_d  = flush_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          gnt_d   = ONE << pick_sel;
          owner_d = pick_sel;
          busy_d  = 1'b1;
          last_d  = pick_sel;
          wd_d    = '0;
        end
      end

      GRANT: begin
        if (lease_end) begin
          state_d     = FLUSH;
          gnt_d       = '0;
          busy_d      = 1'b0;
          accel_rst_d = 1'b1;
          flush_cnt_d = '0;
          if (reclaim) begin
            timeout_d    = 1'b1;
            timeout_id_d = owner_q;
          end
        end else begin
          wd_d = own_act ? '0 : wd_q + 1'b1;
        end
      end

      FLUSH: begin
        if (flush_cnt_q == FC_MAX) begin
          state_d     = IDLE;
          accel_rst_d = 1'b0;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d     = FLUSH;
        gnt_d       = '0;
        busy_d      = 1'b0;
        accel_rst_d = 1'b1;
        flush_cnt_d = '0;
      end
    endcase
  end

  // Reset lands in FLUSH so the accelerator is always scrubbed before a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FLUSH;
      gnt_q        <= '0;
      owner_q      <= '0;
      busy_q       <= 1'b0;
      accel_rst_q  <= 1'b1;
      timeout_q    <= 1'b0;
      timeout_id_q <= '0;
      last_q       <= ID_W'(N_CLIENTS - 1);
      wd_q         <= '0;
      flush_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      busy_q       <= busy_d;
      accel_rst_q  <= accel_rst_d;
      timeout_q    <= timeout_d;
      timeout_id_q <= timeout_id_d;
      last_q       <= last_d;
      wd_q         <= wd_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign owner_o      = owner_q;
  assign busy_o       = busy_q;
  assign accel_rst_o  = accel_rst_q;
  assign timeout_o    = timeout_q;
  assign timeout_id_o = timeout_id_q;

endmodule

// File: tb/tb_accel_lease_arbiter.sv
// Self-checking bench for accel_lease_arbiter: directed scenarios plus a
// randomized run against a lease-level reference model.
module tb_accel_lease_arbiter;

  localparam int N  = 2;
  localparam int LT = 8;
  localparam int FC = 4;

  logic       clk;
  logic       rst;
  logic [1:0] req, rel, act;
  logic [1:0] gnt;
  logic       owner;
  logic       busy, arst, tout, tid;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who holds the lease, how long it has been idle, and how
  // many accelerator-reset cycles remain.
  int m_owner, m_last, m_idle, m_flush, m_tid;
  bit m_tout;

  accel_lease_arbiter #(
    .N_CLIENTS     (N),
    .LEASE_TIMEOUT (LT),
    .FLUSH_CYCLES  (FC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req),
    .rel_i        (rel),
    .act_i        (act),
    .gnt_o        (gnt),
    .owner_o      (owner),
    .busy_o       (busy),
    .accel_rst_o  (arst),
    .timeout_o    (tout),
    .timeout_id_o (tid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_idle  = 0;
    m_flush = FC;
    m_tid   = 0;
    m_tout  = 1'b0;
  endtask

  task automatic model_step();
    int  o;
    int  c;
    bit  a, r, q;
    m_tout = 1'b0;
    if (m_flush > 0) begin
      m_flush--;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (req[c]) begin
          m_owner = c;
          m_last  = c;
          m_idle  = 0;
          break;
        end
      end
    end else begin
      o = m_owner;
      a = act[o];
      r = rel[o];
      q = req[o];
      if (r || !q || (!a && m_idle == LT - 1)) begin
        if (!r && q) begin
          m_tout = 1'b1;
          m_tid  = o;
        end
        m_owner = -1;
        m_flush = FC;
      end else begin
        m_idle = a ? 0 : m_idle + 1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0;
    rel = '0;
    act = '0;
    @(posedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_grant(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles && !ok; i++) begin
      tick();
      if (gnt != 2'b00) ok = 1'b1;
    end
    n_checks++;
    if (!ok) $display("FAIL wait_grant: no grant within %0d cycles, gnt=%b required nonzero", max_cycles, gnt);
    else n_pass++;
  endtask

  task automatic test_reset();
    req = '0; rel = '0; act = '0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({gnt, owner, busy, arst, tout, tid} !== 7'b0000100)
      $display("FAIL reset_values: {gnt,owner,busy,arst,tout,tid}=%b required 0000100",
               {gnt, owner, busy, arst, tout, tid});
    else n_pass++;
    #1 rst = 1'b0;
    model_reset();
    for (int i = 1; i <= 6; i++) begin
      tick();
      n_checks++;
      if ({arst, gnt} !== {(i < 4), 2'b00})
        $display("FAIL reset_flush[%0d]: arst=%b gnt=%b required arst=%b gnt=00", i, arst, gnt, (i < 4));
      else n_pass++;
    end
  endtask

  task automatic test_single_grant();
    do_reset();
    repeat (4) tick();
    req = 2'b01;
    act = 2'b01;
    tick();
    n_checks++;
    if ({gnt, owner, busy, arst} !== 5'b01010)
      $display("FAIL grant_latency: gnt=%b owner=%b busy=%b arst=%b required 01/0/1/0", gnt, owner, busy, arst);
    else n_pass++;
    repeat (9) tick();
    n_checks++;
    if (gnt !== 2'b01) $display("FAIL grant_hold: gnt=%b required 01", gnt);
    else n_pass++;
    rel = 2'b01;
    tick();
    rel = 2'b00;
    for (int i = 1; i <= 6; i++) begin
      n_checks++;
      if (i <= 4) begin
        if ({gnt, busy, arst, tout} !== 5'b00010)
          $display("FAIL release_flush[%0d]: gnt=%b busy=%b arst=%b tout=%b required 00/0/1/0", i, gnt, busy, arst, tout);
        else n_pass++;
      end else if (i == 5) begin
        if ({gnt, arst} !== 3'b000)
          $display("FAIL flush_end: gnt=%b arst=%b required 00/0", gnt, arst);
        else n_pass++;
      end else begin
        if (gnt !== 2'b01)
          $display("FAIL regrant_turnaround: gnt=%b required 01", gnt);
        else n_pass++;
      end
      if (i < 6) tick();
    end
    req = 2'b00;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_seq [4];
    bit ok;
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_grant(12, ok);
      if (ok) begin
        n_checks++;
        if (gnt !== exp_seq[k]) $display("FAIL rr_order[%0d]: gnt=%b required %b", k, gnt, exp_seq[k]);
        else n_pass++;
        repeat (4) tick();
        rel = gnt;
        tick();
        rel = 2'b00;
        n_checks++;
        if ({gnt, arst} !== 3'b001) $display("FAIL rr_release[%0d]: gnt=%b arst=%b required 00/1", k, gnt, arst);
        else n_pass++;
      end
    end
    req = 2'b00;
  endtask

  task automatic test_watchdog();
    bit ok;
    bit early;
    do_reset();
    req = 2'b10;
    wait_grant(8, ok);
    n_checks++;
    if ({gnt, owner} !== 3'b101) $display("FAIL wd_grant: gnt=%b owner=%b required 10/1", gnt, owner);
    else n_pass++;
    early = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (tout || gnt !== 2'b10) early = 1'b1;
    end
    n_checks++;
    if (early) $display("FAIL wd_early: lease lost before %0d idle cycles, gnt=%b tout=%b", LT, gnt, tout);
    else n_pass++;
    tick();
    n_checks++;
    if ({tout, tid, gnt, arst} !== 5'b11001)
      $display("FAIL wd_timeout: tout=%b tid=%b gnt=%b arst=%b required 1/1/00/1", tout, tid, gnt, arst);
    else n_pass++;
    early = 1'b0;
    for (int i = 9; i <= 11; i++) begin
      tick();
      if (!arst || tout) early = 1'b1;
    end
    tick();
    n_checks++;
    if (early || arst || tid !== 1'b1)
      $display("FAIL wd_flush: bad flush after timeout, arst=%b tid=%b required 0/1 after 4 cycles", arst, tid);
    else n_pass++;
    req = 2'b00;
  endtask

  task automatic test_activity_and_release();
    bit ok;
    bit lost;
    bit bad;
    do_reset();
    req = 2'b01;
    wait_grant(8, ok);
    lost = 1'b0;
    for (int i = 0; i < 100; i++) begin
      act = (i % 7 == 6) ? 2'b01 : 2'b00;
      tick();
      if (tout || gnt !== 2'b01) lost = 1'b1;
    end
    act = 2'b00;
    n_checks++;
    if (lost) $display("FAIL activity_keeps_lease: lease lost, gnt=%b tout=%b required 01/0", gnt, tout);
    else n_pass++;
    req = 2'b00;
    tick();
    n_checks++;
    if ({tout, gnt, arst} !== 4'b0001)
      $display("FAIL req_drop_end: tout=%b gnt=%b arst=%b required 0/00/1", tout, gnt, arst);
    else n_pass++;
    req = 2'b01;
    wait_grant(8, ok);
    repeat (7) tick();
    rel = 2'b01;
    tick();
    rel = 2'b00;
    n_checks++;
    if ({tout, gnt, arst} !== 4'b0001)
      $display("FAIL release_beats_timeout: tout=%b gnt=%b arst=%b required 0/00/1", tout, gnt, arst);
    else n_pass++;
    bad = 1'b0;
    repeat (3) begin
      tick();
      if (!arst || tout) bad = 1'b1;
    end
    tick();
    n_checks++;
    if (bad || arst) $display("FAIL release_beats_timeout_flush: arst=%b required 4-cycle flush then 0", arst);
    else n_pass++;
    req = 2'b00;
  endtask

  task automatic test_foreign_and_mid_reset();
    bit ok;
    bit seen;
    bit bad;
    do_reset();
    req = 2'b11;
    act = 2'b01;
    wait_grant(8, ok);
    n_checks++;
    if (gnt !== 2'b01) $display("FAIL foreign_setup: gnt=%b required 01", gnt);
    else n_pass++;
    rel = 2'b10;
    tick();
    rel = 2'b00;
    n_checks++;
    if ({gnt, busy, arst} !== 4'b0110)
      $display("FAIL foreign_release: gnt=%b busy=%b arst=%b required 01/1/0", gnt, busy, arst);
    else n_pass++;
    act = 2'b10;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      if (tout && tid == 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (!seen) $display("FAIL foreign_act_ignored: tout=%b tid=%b required timeout of core 0", tout, tid);
    else n_pass++;
    wait_grant(10, ok);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({gnt, busy, arst} !== 4'b0001)
      $display("FAIL async_reset: gnt=%b busy=%b arst=%b required 00/0/1", gnt, busy, arst);
    else n_pass++;
    #1 rst = 1'b0;
    model_reset();
    bad = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (!arst || gnt !== 2'b00) bad = 1'b1;
    end
    tick();
    n_checks++;
    if (bad || arst) $display("FAIL reset_mid_lease_flush: arst=%b gnt=%b required full flush", arst, gnt);
    else n_pass++;
    tick();
    n_checks++;
    if (gnt !== 2'b01) $display("FAIL post_reset_pointer: gnt=%b required 01", gnt);
    else n_pass++;
    req = 2'b00;
    act = 2'b00;
  endtask

  task automatic test_random();
    logic [1:0] e_gnt;
    logic       e_busy, e_arst;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 5) == 0) req = 2'($urandom_range(0, 3));
      rel = {($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0)};
      act = {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)};
      tick();
      e_busy = (m_owner >= 0);
      e_gnt  = e_busy ? (2'b01 << m_owner) : 2'b00;
      e_arst = (m_flush > 0);
      n_checks++;
      if ({gnt, busy, arst, tout, tid} !== {e_gnt, e_busy, e_arst, m_tout, m_tid[0]})
        $display("FAIL random[%0d]: {gnt,busy,arst,tout,tid}=%b required %b", cyc,
                 {gnt, busy, arst, tout, tid}, {e_gnt, e_busy, e_arst, m_tout, m_tid[0]});
      else n_pass++;
      if (e_busy) begin
        n_checks++;
        if (owner !== m_owner[0]) $display("FAIL random_owner[%0d]: owner=%b required %0d", cyc, owner, m_owner);
        else n_pass++;
      end
    end
    req = '0; rel = '0; act = '0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0; rel = '0; act = '0;
    model_reset();
    test_reset();
    test_single_grant();
    test_round_robin();
    test_watchdog();
    test_activity_and_release();
    test_foreign_and_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL sim_timeout: bench did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
